exu_mdu_ctrl: RTL and testbench
===============================

EXU_MDU_CTRL -- requirements
Module: exu_mdu_ctrl

Interface
REQ-001 The block SHALL take parameter XLEN, default 32, as the operand/result width; legal values are 32 and 64.
REQ-002 The block SHALL take parameter MUL_LAT, default 2, as the multiplier pipeline depth in cycles; legal range is 1..4.
REQ-003 Port clk  in  1  is the single clock, and all state SHALL update on its rising edge.
REQ-004 Port rst_n  in  1  is the reset: synchronous, active-low.
REQ-005 Port in_valid  in  1  SHALL indicate that an execute-stage op is presented.
REQ-006 Port in_ready  out  1  SHALL indicate that the block accepts an op this cycle.
REQ-007 Port alu_op  in  3  SHALL carry the op class, encoded as: 000 add-class, 001 branch, 010 R-type, 011 I-ALU, 100 jump.
REQ-008 Ports func3  in  3  and func7  in  7  SHALL carry the instruction fields; func7 is the full 7-bit field.
REQ-009 Ports rs1, rs2  in  XLEN  SHALL carry the operands.
REQ-010 Port flush  in  1  SHALL carry the pipeline kill.
REQ-011 Port alu_ctrl  out  4  SHALL carry the single-cycle ALU code (combinational).
REQ-012 Port is_mdu  out  1  SHALL flag that the current op is RV32M/RV64M-class.
REQ-013 Port illegal  out  1  SHALL flag an undecodable op; when it is high, alu_ctrl SHALL be 4'b1111.
REQ-014 Port out_valid  out  1  SHALL mark that an MDU result is available; port out_ready  in  1  SHALL carry consumer acceptance.
REQ-015 Port result  out  XLEN  SHALL carry the MDU result; port busy  out  1  SHALL be high while the FSM is not in IDLE.

Function
REQ-016 Non-MDU decode SHALL be combinational: add-class->ADD; branch BEQ/BNE/BLT/BGE/BLTU/BGEU->SUB/NOTEQ/SLT/SGE/SLTU/SGEU; R-type and I-ALU->standard RV32I codes; jump->JUMP; any other code->illegal.
REQ-017 The op SHALL be an MDU op (is_mdu=1) iff alu_op=010 and func7=0000001; func3 then selects MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
REQ-018 For an R-type op, func7 values other than 0000000, 0100000 (SUB/SRA only) and 0000001 SHALL raise illegal.
REQ-019 in_ready SHALL be 1 in IDLE and 0 in every other state; non-MDU ops SHALL never enter the FSM.
REQ-020 The FSM SHALL have states IDLE, MUL, DIV and DONE.
REQ-021 From IDLE, an accepted MDU op (in_valid & in_ready & is_mdu & !flush) SHALL latch the operands and go to MUL (multiply ops) or DIV (divide/remainder ops).
REQ-022 MUL SHALL advance to DONE after MUL_LAT cycles; out_valid SHALL rise MUL_LAT cycles after the accepting edge.
REQ-023 MUL SHALL compute a 2*XLEN product with rs1 and rs2 sign- or zero-extended per op; MUL returns the low XLEN bits, and MULH/MULHSU/MULHU return the high XLEN bits.
REQ-024 DIV SHALL use an iterative restoring divider at one bit per cycle on magnitudes and fix the signs on the final cycle; out_valid SHALL rise XLEN+1 cycles after the accepting edge.
REQ-025 Divide by zero SHALL bypass iteration with out_valid 1 cycle after accept: quotient = all ones, remainder = rs1.
REQ-026 Signed overflow (rs1 = most-negative, rs2 = -1) SHALL likewise complete in 1 cycle: quotient = rs1, remainder = 0.
REQ-027 In DONE, out_valid SHALL be 1 and result SHALL be held stable; on out_ready=1 the FSM SHALL return to IDLE, and out_ready=0 SHALL hold it in DONE indefinitely.
REQ-028 A new op SHALL be accepted no earlier than the cycle after DONE exits (no result/accept overlap).
REQ-029 flush=1 in any state SHALL force IDLE on the next edge, drop out_valid and discard the in-flight op; flush SHALL take priority over in_valid and over out_ready in the same cycle.
REQ-030 alu_ctrl, is_mdu and illegal SHALL reflect the inputs in every state, independent of FSM state.

Reset
REQ-031 While rst_n=0 at a clock edge, the block SHALL set state to IDLE, out_valid=0, busy=0, result=0 and the iteration counter to 0.
REQ-032 Reset asserted mid-operation SHALL abort the op with no out_valid pulse.
REQ-033 The first op SHALL be accepted in the cycle after rst_n returns high.

Structure
REQ-034 A shared package SHALL hold the 4-bit ALU codes (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, NOTEQ, SGE, SGEU, JUMP, ILLEGAL=4'b1111), the alu_op class codes, the func3 MDU op constants and the FSM state type.
REQ-035 The iterative divider SHALL be one sub-module, mdu_div_iter (start, signed-mode, operands in; done, quotient, remainder out); the multiplier SHALL stay inline as a MUL_LAT-stage register chain.

Verification
REQ-036 MUL 7 x -3 (XLEN=32, MUL_LAT=2) -> result 0xFFFFFFEB, with out_valid exactly 2 cycles after accept.
REQ-037 DIV 100/7 -> 14 and REM -100/7 -> 0xFFFFFFFE, each with out_valid 33 cycles after accept.
REQ-038 DIVU 5/0 -> 0xFFFFFFFF and DIV 0x80000000/-1 -> 0x80000000, each with out_valid 1 cycle after accept.
REQ-039 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; holding out_ready=0 for 5 cycles -> result stable and in_ready=0 throughout.
REQ-040 flush at cycle 10 of a DIV, alongside a new in_valid -> IDLE next cycle, no out_valid, new op not accepted; rst_n=0 mid-MUL -> no result.
REQ-041 alu_op=010, func3=000, func7=0100000 -> alu_ctrl=SUB and is_mdu=0; func7=0000010 -> illegal=1 and alu_ctrl=4'b1111.

Source files
------------

// File: rtl/exu_mdu_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// exu_mdu_ctrl_pkg
// Shared definitions for the execute-stage ALU decoder and the multiply/divide
// unit controller: 4-bit ALU control codes, alu_op class codes, the func3/func7
// encodings the decoder needs, and the MDU FSM state type.
// -----------------------------------------------------------------------------
package exu_mdu_ctrl_pkg;

    // Single-cycle ALU control codes
    typedef enum logic [3:0] {
        ALU_ADD     = 4'd0,
        ALU_SUB     = 4'd1,
        ALU_SLL     = 4'd2,
        ALU_SLT     = 4'd3,
        ALU_SLTU    = 4'd4,
        ALU_XOR     = 4'd5,
        ALU_SRL     = 4'd6,
        ALU_SRA     = 4'd7,
        ALU_OR      = 4'd8,
        ALU_AND     = 4'd9,
        ALU_NOTEQ   = 4'd10,
        ALU_SGE     = 4'd11,
        ALU_SGEU    = 4'd12,
        ALU_JUMP    = 4'd13,
        ALU_ILLEGAL = 4'b1111
    } alu_ctrl_e;

    // alu_op op-class codes
    localparam logic [2:0] OPC_ADD    = 3'b000;
    localparam logic [2:0] OPC_BRANCH = 3'b001;
    localparam logic [2:0] OPC_RTYPE  = 3'b010;
    localparam logic [2:0] OPC_IALU   = 3'b011;
    localparam logic [2:0] OPC_JUMP   = 3'b100;

    // func7 values recognised for R-type ops
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MDU  = 7'b0000001;

    // func3 encodings of the M-extension ops; func3[2] separates divide from multiply
    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    // MDU controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } mdu_state_e;

    function automatic logic is_div_op(input logic [2:0] f3);
        return f3[2];
    endfunction

endpackage

// File: rtl/exu_mdu_ctrl_div.sv
// -----------------------------------------------------------------------------
// mdu_div_iter
// Iterative restoring divider, one quotient bit per cycle, working on operand
// magnitudes. Signs are applied to the outputs after the last iteration.
// Divide-by-zero and signed overflow finish on the start edge without iterating.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   start             load operands and begin (one-cycle pulse)
//   signed_mode       treat operands as two's complement
//   dividend, divisor operands (sampled on start)
//   done              result valid; held until the next start
//   quotient          signed/unsigned quotient
//   remainder         signed/unsigned remainder (sign follows dividend)
// -----------------------------------------------------------------------------
module mdu_div_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            signed_mode,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            done,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST_ITER = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    logic            run_q;
    logic            done_q;
    logic [CW-1:0]   cnt_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] dvs_q;
    logic            neg_q_q;
    logic            neg_r_q;

    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            div_zero;
    logic            overflow;
    logic [XLEN:0]   rem_shift;
    logic [XLEN:0]   diff;

    assign a_neg     = signed_mode & dividend[XLEN-1];
    assign b_neg     = signed_mode & divisor[XLEN-1];
    assign a_mag     = a_neg ? -dividend : dividend;
    assign b_mag     = b_neg ? -divisor  : divisor;
    assign div_zero  = (divisor == '0);
    assign overflow  = signed_mode && (dividend == MOST_NEG) && (divisor == '1);

    // Shift the next dividend bit (MSB of the quotient register) into the
    // partial remainder, then trial-subtract the divisor.
    assign rem_shift = {rem_q, quo_q[XLEN-1]};
    assign diff      = rem_shift - {1'b0, dvs_q};

    // Control: run flag, done flag, iteration counter
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            run_q  <= 1'b0;
            done_q <= 1'b0;
            cnt_q  <= '0;
        end else if (start) begin
            run_q  <= !(div_zero || overflow);
            done_q <= div_zero || overflow;
            cnt_q  <= '0;
        end else if (run_q) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST_ITER) begin
                run_q  <= 1'b0;
                done_q <= 1'b1;
            end
        end
    end

    // Datapath: only qualified by done_q, so it carries no reset
    always_ff @(posedge clk) begin
        if (start) begin
            if (div_zero) begin
                quo_q   <= '1;
                rem_q   <= dividend;
                dvs_q   <= divisor;
                neg_q_q <= 1'b0;
                neg_r_q <= 1'b0;
            end else if (overflow) begin
                quo_q   <= dividend;
                rem_q   <= '0;
                dvs_q   <= divisor;
                neg_q_q <= 1'b0;
                neg_r_q <= 1'b0;
            end else begin
                quo_q   <= a_mag;
                rem_q   <= '0;
                dvs_q   <= b_mag;
                neg_q_q <= a_neg ^ b_neg;
                neg_r_q <= a_neg;
            end
        end else if (run_q) begin
            if (!diff[XLEN]) begin
                rem_q <= diff[XLEN-1:0];
                quo_q <= {quo_q[XLEN-2:0], 1'b1};
            end else begin
                rem_q <= rem_shift[XLEN-1:0];
                quo_q <= {quo_q[XLEN-2:0], 1'b0};
            end
        end
    end

    assign done      = done_q;
    assign quotient  = neg_q_q ? -quo_q : quo_q;
    assign remainder = neg_r_q ? -rem_q : rem_q;

endmodule

// File: rtl/exu_mdu_ctrl.sv
// -----------------------------------------------------------------------------
// exu_mdu_ctrl
// Execute-stage control: combinational ALU decode for base ops, plus an FSM
// that sequences multi-cycle multiply (pipelined) and divide (iterative) ops.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   in_valid/in_ready op handshake (ready only in IDLE)
//   alu_op, func3, func7  op class and instruction fields
//   rs1, rs2          operands
//   flush             pipeline kill, highest priority
//   alu_ctrl          single-cycle ALU code (combinational)
//   is_mdu, illegal   decode flags (combinational)
//   out_valid/out_ready  MDU result handshake
//   result            MDU result, held stable in DONE
//   busy              FSM not in IDLE
// -----------------------------------------------------------------------------
module exu_mdu_ctrl
    import exu_mdu_ctrl_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int MUL_LAT = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      alu_op,
    input  logic [2:0]      func3,
    input  logic [6:0]      func7,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic [3:0]      alu_ctrl,
    output logic            is_mdu,
    output logic            illegal,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam logic [2:0] MUL_LAST = 3'(MUL_LAT - 1);

    // ------------------------------------------------------------------ decode
    alu_ctrl_e ctrl;
    logic      mdu;
    logic      ill;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        ctrl = ALU_ADD;
        mdu  = 1'b0;
        ill  = 1'b0;
        case (alu_op)
            OPC_ADD:    ctrl = ALU_ADD;
            OPC_BRANCH: begin
                case (func3)
                    3'b000:  ctrl = ALU_SUB;
                    3'b001:  ctrl = ALU_NOTEQ;
                    3'b100:  ctrl = ALU_SLT;
                    3'b101:  ctrl = ALU_SGE;
                    3'b110:  ctrl = ALU_SLTU;
                    3'b111:  ctrl = ALU_SGEU;
                    default: ill  = 1'b1;
                endcase
            end
            OPC_RTYPE: begin
                if (func7 == F7_MDU) begin
                    mdu = 1'b1;
                end else if (func7 == F7_BASE) begin
                    case (func3)
                        3'b000: ctrl = ALU_ADD;
                        3'b001: ctrl = ALU_SLL;
                        3'b010: ctrl = ALU_SLT;
                        3'b011: ctrl = ALU_SLTU;
                        3'b100: ctrl = ALU_XOR;
                        3'b101: ctrl = ALU_SRL;
                        3'b110: ctrl = ALU_OR;
                        3'b111: ctrl = ALU_AND;
                    endcase
                end else if (func7 == F7_ALT) begin
                    case (func3)
                        3'b000:  ctrl = ALU_SUB;
                        3'b101:  ctrl = ALU_SRA;
                        default: ill  = 1'b1;
                    endcase
                end else begin
                    ill = 1'b1;
                end
            end
            OPC_IALU: begin
                case (func3)
                    3'b000: ctrl = ALU_ADD;
                    3'b001: ctrl = ALU_SLL;
                    3'b010: ctrl = ALU_SLT;
                    3'b011: ctrl = ALU_SLTU;
                    3'b100: ctrl = ALU_XOR;
                    3'b101: ctrl = func7[5] ? ALU_SRA : ALU_SRL;
                    3'b110: ctrl = ALU_OR;
                    3'b111: ctrl = ALU_AND;
                endcase
            end
            OPC_JUMP:   ctrl = ALU_JUMP;
            default:    ill  = 1'b1;
        endcase
        if (ill) ctrl = ALU_ILLEGAL;
    end

    assign alu_ctrl = ctrl;
    assign is_mdu   = mdu;
    assign illegal  = ill;

    // ------------------------------------------------------------------ FSM
    mdu_state_e state_q, state_d;
    logic [2:0]      cnt_q;
    logic [2:0]      op_q;
    logic [XLEN-1:0] result_q;
    logic            accept;

    assign in_ready  = (state_q == ST_IDLE);
    assign accept    = in_valid && in_ready && mdu && !flush;
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign result    = result_q;

    // Divider
    logic            div_done;
    logic [XLEN-1:0] div_quo;
    logic [XLEN-1:0] div_rem;

    mdu_div_iter #(.XLEN(XLEN)) u_div (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (accept && is_div_op(func3)),
        .signed_mode (!func3[0]),
        .dividend    (rs1),
        .divisor     (rs2),
        .done        (div_done),
        .quotient    (div_quo),
        .remainder   (div_rem)
    );

    // Multiplier: operands sign/zero-extended to 2*XLEN, product captured in
    // stage 0 on accept and shifted down the chain one stage per cycle.
    logic            mul_sa;
    logic            mul_sb;
    logic [2*XLEN-1:0] mul_a;
    logic [2*XLEN-1:0] mul_b;
    logic [2*XLEN-1:0] mul_pipe [MUL_LAT];
    logic [2*XLEN-1:0] mul_last;
    logic [XLEN-1:0]   mul_sel;

    assign mul_sa   = (func3 == F3_MULH) || (func3 == F3_MULHSU);
    assign mul_sb   = (func3 == F3_MULH);
    assign mul_a    = {{XLEN{mul_sa & rs1[XLEN-1]}}, rs1};
    assign mul_b    = {{XLEN{mul_sb & rs2[XLEN-1]}}, rs2};
    assign mul_last = mul_pipe[MUL_LAT-1];
    assign mul_sel  = (op_q == F3_MUL) ? mul_last[XLEN-1:0] : mul_last[2*XLEN-1:XLEN];

    // NOTE: the product chain is pure datapath whose contents are only used
    // once the FSM reaches DONE, so it is deliberately left without reset.
    always_ff @(posedge clk) begin
        if (accept && !is_div_op(func3)) mul_pipe[0] <= mul_a * mul_b;
        for (int i = 1; i < MUL_LAT; i++) mul_pipe[i] <= mul_pipe[i-1];
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = is_div_op(func3) ? ST_DIV : ST_MUL;
            ST_MUL:  if (cnt_q == MUL_LAST) state_d = ST_DONE;
            ST_DIV:  if (div_done) state_d = ST_DONE;
            ST_DONE: if (out_ready) state_d = ST_IDLE;
        endcase
        // Kill wins over accept, completion and consumer handshake alike
        if (flush) state_d = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            result_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q  <= func3;
                cnt_q <= '0;
            end else if (state_q == ST_MUL) begin
                cnt_q <= cnt_q + 3'd1;
            end
            if (state_d == ST_DONE && state_q == ST_MUL) result_q <= mul_sel;
            if (state_d == ST_DONE && state_q == ST_DIV) result_q <= op_q[1] ? div_rem : div_quo;
        end
    end

endmodule

// File: tb/tb_exu_mdu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_exu_mdu_ctrl
// Directed bench for exu_mdu_ctrl (XLEN=32, MUL_LAT=2): reset state, multiply
// and divide results with their latencies, special divide cases, output hold
// under back-pressure, flush and reset aborts, and combinational decode.
// -----------------------------------------------------------------------------
module tb_exu_mdu_ctrl;
    import exu_mdu_ctrl_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  alu_op;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        flush;
    logic [3:0]  alu_ctrl;
    logic        is_mdu;
    logic        illegal;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    exu_mdu_ctrl #(.XLEN(32), .MUL_LAT(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .func3     (func3),
        .func7     (func7),
        .rs1       (rs1),
        .rs2       (rs2),
        .flush     (flush),
        .alu_ctrl  (alu_ctrl),
        .is_mdu    (is_mdu),
        .illegal   (illegal),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Presents an MDU op at the current negedge, waits (bounded) for out_valid,
    // optionally holds out_ready low, then completes the handshake.
    task automatic run_mdu(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                           input int hold);
        int lat;
        alu_op   = OPC_RTYPE;
        func3    = f3;
        func7    = F7_MDU;
        rs1      = a;
        rs2      = b;
        in_valid = 1'b1;
        #1;
        check({tag, " in_ready"}, 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, " busy"}, 64'({busy, out_valid}), 64'b10);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " result"}, 64'(result), 64'(exp));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, " hold"}, 64'({out_valid, in_ready, result}), 64'({1'b1, 1'b0, exp}));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, " release"}, 64'({busy, in_ready, out_valid}), 64'b010);
    endtask

    task automatic chk_dec(input string tag, input logic [2:0] op, input logic [2:0] f3,
                           input logic [6:0] f7, input logic [3:0] exp_ctrl,
                           input logic exp_mdu, input logic exp_ill);
        alu_op = op;
        func3  = f3;
        func7  = f7;
        #1;
        check(tag, 64'({alu_ctrl, is_mdu, illegal}), 64'({exp_ctrl, exp_mdu, exp_ill}));
    endtask

    initial begin
        int seen;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        alu_op    = OPC_ADD;
        func3     = 3'b000;
        func7     = 7'b0;
        rs1       = '0;
        rs2       = '0;
        flush     = 1'b0;
        out_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset result", 64'(result), 64'd0);
        check("reset in_ready", 64'(in_ready), 64'd1);

        // First op presented as reset releases: accepted on the very next edge
        rst_n = 1'b1;
        run_mdu("mul 7x-3", F3_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 2, 0);
        run_mdu("div 100/7", F3_DIV, 32'd100, 32'd7, 32'd14, 33, 0);
        run_mdu("rem -100/7", F3_REM, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 33, 0);
        run_mdu("divu 5/0", F3_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0);
        run_mdu("rem 9/0", F3_REM, 32'd9, 32'd0, 32'd9, 1, 0);
        run_mdu("div ovf", F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
        run_mdu("rem ovf", F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 0);
        run_mdu("mulhu max", F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2, 5);
        run_mdu("mulh minsq", F3_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 2, 0);
        run_mdu("mulhsu -1x2", F3_MULHSU, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 2, 0);
        run_mdu("remu 100/7", F3_REMU, 32'd100, 32'd7, 32'd2, 33, 0);
        run_mdu("div -7/2", F3_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 0);

        // Flush at cycle 10 of a divide, alongside a new op
        alu_op   = OPC_RTYPE;
        func3    = F3_DIV;
        func7    = F7_MDU;
        rs1      = 32'd100;
        rs2      = 32'd7;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        // Decode stays live while the FSM is busy
        chk_dec("dec busy bne", OPC_BRANCH, 3'b001, 7'b0, ALU_NOTEQ, 1'b0, 1'b0);
        check("flush busy before", 64'(busy), 64'd1);
        repeat (9) @(negedge clk);
        alu_op   = OPC_RTYPE;
        func3    = F3_MUL;
        func7    = F7_MDU;
        flush    = 1'b1;
        in_valid = 1'b1;
        #1;
        check("flush in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush idle", 64'({busy, out_valid, in_ready}), 64'b001);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid || busy) seen++;
        end
        check("flush quiet", 64'(seen), 64'd0);

        // Reset mid-multiply
        alu_op   = OPC_RTYPE;
        func3    = F3_MUL;
        func7    = F7_MDU;
        rs1      = 32'd7;
        rs2      = 32'd9;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("rst mid busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rst mid state", 64'({busy, out_valid, result}), 64'd0);
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("rst mid quiet", 64'(seen), 64'd0);
        run_mdu("mul after rst", F3_MUL, 32'd3, 32'd4, 32'd12, 2, 0);

        // Combinational decode
        chk_dec("dec sub", OPC_RTYPE, 3'b000, 7'b0100000, ALU_SUB, 1'b0, 1'b0);
        chk_dec("dec bad f7", OPC_RTYPE, 3'b000, 7'b0000010, ALU_ILLEGAL, 1'b0, 1'b1);
        chk_dec("dec mdu", OPC_RTYPE, 3'b100, 7'b0000001, ALU_ADD, 1'b1, 1'b0);
        chk_dec("dec alt xor", OPC_RTYPE, 3'b100, 7'b0100000, ALU_ILLEGAL, 1'b0, 1'b1);
        chk_dec("dec and", OPC_RTYPE, 3'b111, 7'b0, ALU_AND, 1'b0, 1'b0);
        chk_dec("dec sra", OPC_RTYPE, 3'b101, 7'b0100000, ALU_SRA, 1'b0, 1'b0);
        chk_dec("dec srai", OPC_IALU, 3'b101, 7'b0100000, ALU_SRA, 1'b0, 1'b0);
        chk_dec("dec sltiu", OPC_IALU, 3'b011, 7'b0, ALU_SLTU, 1'b0, 1'b0);
        chk_dec("dec add", OPC_ADD, 3'b111, 7'b1111111, ALU_ADD, 1'b0, 1'b0);
        chk_dec("dec beq", OPC_BRANCH, 3'b000, 7'b0, ALU_SUB, 1'b0, 1'b0);
        chk_dec("dec bge", OPC_BRANCH, 3'b101, 7'b0, ALU_SGE, 1'b0, 1'b0);
        chk_dec("dec bgeu", OPC_BRANCH, 3'b111, 7'b0, ALU_SGEU, 1'b0, 1'b0);
        chk_dec("dec br bad", OPC_BRANCH, 3'b010, 7'b0, ALU_ILLEGAL, 1'b0, 1'b1);
        chk_dec("dec jump", OPC_JUMP, 3'b000, 7'b0, ALU_JUMP, 1'b0, 1'b0);
        chk_dec("dec bad op", 3'b101, 3'b000, 7'b0, ALU_ILLEGAL, 1'b0, 1'b1);
        chk_dec("dec bad op7", 3'b111, 3'b000, 7'b0, ALU_ILLEGAL, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
